batch_sequencer: RTL and testbench

BATCH_SEQUENCER -- requirements
Module: batch_sequencer

---
 rtl/batch_seq_pkg.sv | 24 ++
 rtl/seq_mac.sv | 40 ++++
 rtl/batch_sequencer.sv | 169 ++++++++++++++++
 tb/tb_batch_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/batch_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : batch_seq_pkg
//  Description : Shared dimensions and FSM encoding for the batch sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package batch_seq_pkg;

    localparam int BATCH_DIM = 8;
    localparam int IDX_W     = $clog2(BATCH_DIM);
    localparam int ACC_W     = 32;
    localparam int MAX_ITER  = BATCH_DIM * BATCH_DIM;
    localparam int ST_W      = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_FETCH = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mac.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mac
//  Description : Signed 8x8 multiply-accumulate with clear and enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mac #(
    parameter int ACC_W = batch_seq_pkg::ACC_W
) (
    input  logic               i_clk,
    input  logic               i_clr,
    input  logic               i_acc_clr,
    input  logic               i_en,
    input  logic signed [7:0]  i_a,
    input  logic signed [7:0]  i_b,
    output logic [ACC_W-1:0]   o_acc
);
    import batch_seq_pkg::*;

    logic signed [15:0] w_prod;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};
    assign o_acc      = r_acc;

    // Accumulator: clear has priority; products wrap with no saturation.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_acc <= '0;
        end else if (i_acc_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

endmodule
`default_nettype wire

// File: rtl/batch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : batch_sequencer
//  Description : Sequences C = D x W over two 8x8 batch buffers, one element
//                per run step, with valid/ready result hand-off.
//  Revision    : 1.0 - initial release
// ============================================================================
module batch_sequencer #(
    parameter int BATCH_DIM = batch_seq_pkg::BATCH_DIM,
    parameter int ACC_W     = batch_seq_pkg::ACC_W,
    parameter int MAX_ITER  = batch_seq_pkg::MAX_ITER
) (
    input  logic                         i_clk,
    input  logic                         i_clr,
    input  logic [31:0]                  i_iterations,
    input  logic                         i_iterations_write,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(BATCH_DIM)-1:0] o_rd_row_d,
    output logic [$clog2(BATCH_DIM)-1:0] o_rd_col_d,
    input  logic [7:0]                   i_data,
    input  logic [BATCH_DIM-1:0]         i_data_sticky,
    output logic [$clog2(BATCH_DIM)-1:0] o_rd_row_w,
    output logic [$clog2(BATCH_DIM)-1:0] o_rd_col_w,
    input  logic [7:0]                   i_weight,
    input  logic [BATCH_DIM-1:0]         i_weight_sticky,
    output logic [ACC_W-1:0]             o_res,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic                         o_batch_clr
);
    import batch_seq_pkg::*;

    localparam int IDX_W = $clog2(BATCH_DIM);
    localparam int CNT_W = $clog2(MAX_ITER + 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(BATCH_DIM - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] w_iter_cap;
    logic [IDX_W-1:0] r_row, r_col, r_k;
    logic [IDX_W-1:0] r_rd_row_d, r_rd_col_d, r_rd_row_w, r_rd_col_w;
    logic             r_fetch_d, r_done, r_batch_clr;
    logic             w_go, w_hs, w_last, w_acc_clr;

    // Requested count clamped to one full batch.
    assign w_iter_cap = (i_iterations > 32'(MAX_ITER)) ? CNT_W'(MAX_ITER)
                                                        : i_iterations[CNT_W-1:0];
    assign w_go   = i_data_sticky[r_row] && (&i_weight_sticky);
    assign w_hs   = (r_state == ST_OUT) && i_res_ready;
    assign w_last = (r_remain == CNT_W'(1));

    assign o_rd_row_d  = r_rd_row_d;
    assign o_rd_col_d  = r_rd_col_d;
    assign o_rd_row_w  = r_rd_row_w;
    assign o_rd_col_w  = r_rd_col_w;
    assign o_done      = r_done;
    assign o_batch_clr = r_batch_clr;

    // State register; clear aborts any run.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_iterations_write && (w_iter_cap != '0)) w_next = ST_WAIT;
            ST_WAIT:  if (w_go) w_next = ST_FETCH;
            ST_FETCH: if (r_k == c_IDX_LAST) w_next = ST_DRAIN;
            ST_DRAIN: w_next = ST_OUT;
            ST_OUT:   if (i_res_ready) w_next = w_last ? ST_IDLE : ST_WAIT;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs and MAC control.
    always_comb begin
        o_busy      = (r_state != ST_IDLE);
        o_res_valid = (r_state == ST_OUT);
        w_acc_clr   = (r_state == ST_FETCH) && (r_k == '0);
    end

    // Run bookkeeping, element indices and registered read addresses.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_remain    <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_k         <= '0;
            r_rd_row_d  <= '0;
            r_rd_col_d  <= '0;
            r_rd_row_w  <= '0;
            r_rd_col_w  <= '0;
            r_fetch_d   <= 1'b0;
            r_done      <= 1'b0;
            r_batch_clr <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_batch_clr <= 1'b0;
            // Data for the address issued this cycle returns next cycle.
            r_fetch_d   <= (r_state == ST_FETCH);
            case (r_state)
                ST_IDLE: begin
                    if (i_iterations_write) begin
                        r_remain <= w_iter_cap;
                        r_row    <= '0;
                        r_col    <= '0;
                        if (w_iter_cap == '0) begin
                            r_done      <= 1'b1;
                            r_batch_clr <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_go) begin
                        r_k        <= '0;
                        r_rd_row_d <= r_row;
                        r_rd_col_d <= '0;
                        r_rd_row_w <= '0;
                        r_rd_col_w <= r_col;
                    end
                end
                ST_FETCH: begin
                    if (r_k != c_IDX_LAST) begin
                        r_k        <= r_k + IDX_W'(1);
                        r_rd_col_d <= r_k + IDX_W'(1);
                        r_rd_row_w <= r_k + IDX_W'(1);
                    end
                end
                ST_OUT: begin
                    if (w_hs) begin
                        r_remain <= r_remain - CNT_W'(1);
                        if (w_last) begin
                            r_done      <= 1'b1;
                            r_batch_clr <= 1'b1;
                        end else if (r_col == c_IDX_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + IDX_W'(1);
                        end else begin
                            r_col <= r_col + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    seq_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .i_clk     (i_clk),
        .i_clr     (i_clr),
        .i_acc_clr (w_acc_clr),
        .i_en      (r_fetch_d),
        .i_a       (i_data),
        .i_b       (i_weight),
        .o_acc     (o_res)
    );

endmodule
`default_nettype wire

// File: tb/tb_batch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_batch_sequencer
//  Description : Scoreboard bench for batch_sequencer with 1-cycle batch RAMs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_batch_sequencer;

    logic        clk = 1'b0;
    logic        i_clr;
    logic [31:0] i_iterations;
    logic        i_iterations_write;
    logic        o_busy, o_done, o_res_valid, o_batch_clr;
    logic [2:0]  o_rd_row_d, o_rd_col_d, o_rd_row_w, o_rd_col_w;
    logic [7:0]  r_dq, r_wq;
    logic [7:0]  i_data_sticky, i_weight_sticky;
    logic [31:0] o_res;
    logic        i_res_ready;

    logic signed [7:0] dm [0:7][0:7];
    logic signed [7:0] wm [0:7][0:7];

    logic [31:0] sb_q [$];
    int n_checks = 0;
    int n_errs   = 0;
    int n_res    = 0;

    always #5 clk = ~clk;

    batch_sequencer dut (
        .i_clk              (clk),
        .i_clr              (i_clr),
        .i_iterations       (i_iterations),
        .i_iterations_write (i_iterations_write),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_rd_row_d         (o_rd_row_d),
        .o_rd_col_d         (o_rd_col_d),
        .i_data             (r_dq),
        .i_data_sticky      (i_data_sticky),
        .o_rd_row_w         (o_rd_row_w),
        .o_rd_col_w         (o_rd_col_w),
        .i_weight           (r_wq),
        .i_weight_sticky    (i_weight_sticky),
        .o_res              (o_res),
        .o_res_valid        (o_res_valid),
        .i_res_ready        (i_res_ready),
        .o_batch_clr        (o_batch_clr)
    );

    // Batch buffers with one cycle of read latency.
    always @(posedge clk) begin
        r_dq <= dm[o_rd_row_d][o_rd_col_d];
        r_wq <= wm[o_rd_row_w][o_rd_col_w];
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    function automatic logic [31:0] cval(input int r, input int c);
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'(dm[r][k]) * int'(wm[k][c]);
        return 32'(s);
    endfunction

    // Result monitor: every handshake pops and compares one expectation.
    always @(negedge clk) begin
        logic [31:0] exp_v;
        if (o_res_valid && i_res_ready) begin
            chk("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                exp_v = sb_q.pop_front();
                chk("res", 64'(o_res), 64'(exp_v));
                n_res++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int n);
        int cap = (n > 64) ? 64 : n;
        for (int i = 0; i < cap; i++) sb_q.push_back(cval(i / 8, i % 8));
        i_iterations       = 32'(n);
        i_iterations_write = 1'b1;
        tick();
        i_iterations_write = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!o_res_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("valid_seen", 64'(o_res_valid), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(o_done), 64'd1);
    endtask

    task automatic chk_addr(input string tag, input int rd, input int cd, input int rw, input int cw);
        chk({tag, "_row_d"}, 64'(o_rd_row_d), 64'(rd));
        chk({tag, "_col_d"}, 64'(o_rd_col_d), 64'(cd));
        chk({tag, "_row_w"}, 64'(o_rd_row_w), 64'(rw));
        chk({tag, "_col_w"}, 64'(o_rd_col_w), 64'(cw));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"},  64'(o_busy), 64'd0);
        chk({tag, "_done"},  64'(o_done), 64'd0);
        chk({tag, "_valid"}, 64'(o_res_valid), 64'd0);
        chk({tag, "_res"},   64'(o_res), 64'd0);
        chk({tag, "_bclr"},  64'(o_batch_clr), 64'd0);
        chk_addr(tag, 0, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n0, bad, k_row;
        i_clr = 1'b1; i_iterations = '0; i_iterations_write = 1'b0;
        i_data_sticky = 8'hFF; i_weight_sticky = 8'hFF; i_res_ready = 1'b1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin dm[r][c] = 8'sd1; wm[r][c] = 8'sd2; end
        repeat (3) tick();
        chk_reset_outs("rst");
        i_clr = 1'b0;
        tick();

        // All-ones by all-twos, single element: 16 at cycle 11, done at 12.
        start_run(1);
        wait_valid(cyc);
        chk("lat11", 64'(cyc), 64'd11);
        chk("res16", 64'(o_res), 64'd16);
        tick();
        chk("done12", 64'(o_done), 64'd1);
        chk("bclr12", 64'(o_batch_clr), 64'd1);
        chk("busy12", 64'(o_busy), 64'd0);
        tick();
        chk("done_pulse", 64'(o_done), 64'd0);

        // Most negative operands: 8 * 16384.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                dm[r][c] = (r == 0) ? -8'sd128 : 8'sd0;
                wm[r][c] = (c == 0) ? -8'sd128 : 8'sd0;
            end
        start_run(1);
        wait_valid(cyc);
        chk("res_max", 64'(o_res), 64'd131072);
        wait_done(20);
        tick();

        // Weight batch incomplete: hold in WAIT with addresses frozen.
        i_weight_sticky = 8'h7F;
        start_run(1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (!o_busy || o_res_valid || o_rd_row_d != 3'd0 || o_rd_col_d != 3'd7 ||
                o_rd_row_w != 3'd7 || o_rd_col_w != 3'd0) bad++;
            tick();
        end
        chk("wait_hold", 64'(bad), 64'd0);
        i_weight_sticky = 8'hFF;
        cyc = 0;
        while (!o_res_valid && cyc < 50) begin tick(); cyc++; end
        chk("sticky_lat10", 64'(cyc), 64'd10);
        wait_done(20);
        tick();

        // Identity by index matrix, request over the cap: 0..63 then done.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                dm[r][c] = (r == c) ? 8'sd1 : 8'sd0;
                wm[r][c] = 8'(8 * r + c);
            end
        chk("model_c37", 64'(cval(4, 5)), 64'd37);
        n0 = n_res;
        start_run(100);
        wait_done(2000);
        chk("n_res64", 64'(n_res - n0), 64'd64);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        tick();

        // Back-pressure in OUT: result held stable, no fetch.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                dm[r][c] = 8'($urandom_range(0, 255));
                wm[r][c] = 8'($urandom_range(0, 255));
            end
        i_res_ready = 1'b0;
        start_run(2);
        wait_valid(cyc);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(o_res_valid), 64'd1);
            chk("bp_res", 64'(o_res), 64'(sb_q[0]));
            k_row = int'(o_rd_row_w);
            chk("bp_addr_w", 64'(k_row), 64'd7);
            tick();
        end
        i_res_ready = 1'b1;
        wait_done(50);
        chk("bp_drained", 64'(sb_q.size()), 64'd0);
        tick();

        // Start coinciding with the final handshake is ignored.
        start_run(1);
        wait_valid(cyc);
        i_iterations = 32'd5;
        i_iterations_write = 1'b1;
        tick();
        i_iterations_write = 1'b0;
        chk("hs_done", 64'(o_done), 64'd1);
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if (o_busy || o_res_valid) bad++;
            tick();
        end
        chk("start_ignored", 64'(bad), 64'd0);

        // Clear mid-fetch at k=4, then a zero-length run.
        start_run(1);
        repeat (5) tick();
        chk("k4_col_d", 64'(o_rd_col_d), 64'd4);
        chk("k4_busy", 64'(o_busy), 64'd1);
        i_clr = 1'b1;
        tick();
        chk_reset_outs("clr");
        i_clr = 1'b0;
        sb_q.delete();
        start_run(0);
        chk("zero_done", 64'(o_done), 64'd1);
        chk("zero_bclr", 64'(o_batch_clr), 64'd1);
        chk("zero_busy", 64'(o_busy), 64'd0);
        tick();
        chk("zero_done_pulse", 64'(o_done), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
